edge_avg_unit: RTL
==================

# edge_avg_unit

- Downstream consumer of the 8-bit subtractor stage in the edge-preserving noise-reduction datapath.
- Takes a serialized window of neighbour pixels, each with its 9-bit signed difference (neighbour − centre), and keeps only neighbours with |diff| ≤ threshold.
- Outputs the rounded mean of the centre pixel plus the kept neighbours, computed by a serial divider.
- Sits between the subtractor array and the output pixel formatter; valid/ready on both sides.

## Interface
Parameters:
- PIX_W, 8, pixel width; difference width is PIX_W+1
- MAX_TAPS, 8, max neighbour beats per window

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  neighbour beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_center  in  PIX_W  centre pixel; sampled on the first beat of a window only
- in_thr  in  PIX_W  threshold; sampled on the first beat of a window only
- in_pix  in  PIX_W  neighbour pixel
- in_diff  in  PIX_W+1  neighbour − centre, two's complement, as produced by the subtractor
- in_last  in  1  final beat of the window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_pix  out  PIX_W  filtered pixel
- out_cnt  out  4  number of contributors, 1..9

## Operation
- States: IDLE, ACCUM, DIV, OUT.
- in_ready = rst_n & (state==IDLE | state==ACCUM), combinational.
- Acceptance of each beat:
  - abs = in_diff[8] ? −in_diff : in_diff, computed 9 bits wide.
  - accept = (abs ≤ {0,thr}).
  - in_diff = 9'h100 yields abs = 256 and is never accepted.
- IDLE, beat accepted:
  - Registers: center ← in_center; thr ← in_thr.
  - sum ← center + (accept ? in_pix : 0); cnt ← 1 + accept; taps ← 1.
  - Next state is DIV if in_last, else ACCUM.
- ACCUM, beat accepted:
  - sum += accept ? in_pix : 0; cnt += accept; taps += 1.
  - Next state is DIV if in_last or taps reaches MAX_TAPS; in_last is ignored on the MAX_TAPS-th beat, which always closes the window.
- Gaps with in_valid low are allowed anywhere and leave state unchanged.
- Arithmetic:
  - sum is 12 bits; max 9×255 = 2295.
  - Dividend = sum + (cnt>>1), which gives round-half-up.
  - Restoring unsigned division runs 1 quotient bit per cycle, MSB first, 12 iterations.
  - Quotient ≤ 255 by construction; the low PIX_W bits go to out_pix.
- DIV → OUT after the 12th iteration. OUT: out_valid=1, out_pix and out_cnt stable. Handshake (out_valid & out_ready) → IDLE.
- Reset (rst_n low at an edge), from any state including mid-window and mid-DIV:
  - State ← IDLE; the partial window is discarded.
  - out_valid ← 0, out_pix ← 0, out_cnt ← 0, sum/cnt/taps ← 0.
  - in_ready = 0 while rst_n is low.

## Timing
- Beat acceptance: one per cycle in IDLE/ACCUM.
- Latency: last beat accepted at edge E0; DIV iterations at E1..E12; out_valid is high after E12, i.e. 12 cycles after the last-beat edge.
- Output held indefinitely under out_ready low; no input accepted meanwhile.
- After the output handshake edge, in_ready is high in the next cycle; the first beat of the next window can be accepted then.
- Minimum window period: taps + 13 cycles.

## Structure
- Package edge_filt_pkg:
  - PIX_W, DIFF_W = PIX_W+1, SUM_W = 12, CNT_W = 4
  - state enum {IDLE, ACCUM, DIV, OUT}
  - function abs_diff(DIFF_W) returning DIFF_W bits
- Sub-module udiv_serial:
  - 12-bit dividend, 4-bit divisor, start/done.
  - Restoring, 12 cycles; done pulses with the quotient registered.
  - Instantiated once; the FSM starts it on DIV entry.

## Test plan
- Basic window, 3 beats: centre 100, thr 10, beats (110,+10), (95,−5), (200,+100) with in_last on the third → out_cnt 3, out_pix (305+1)/3 = 102, out_valid exactly 12 cycles after the last beat.
- thr 0, all diffs nonzero (centre 50, neighbours 51, 49) → out_cnt 1, out_pix 50. Diff 0 with thr 0 accepted.
- Full window: centre 0, thr 255, 8 beats of (255,+255) → sum 2040, cnt 9, out_pix (2040+4)/9 = 227. A beat with diff 9'h100 is rejected.
- Backpressure:
  - out_ready low 5 cycles → out_pix/out_cnt stable, in_ready 0.
  - Then handshake → in_ready 1 next cycle.
  - Random in_valid gaps give the same result.
- 9 beats, no in_last:
  - The 8th beat closes the window.
  - The 9th beat becomes the first beat of the next window; its in_center and in_thr are sampled.
- Reset:
  - rst_n low during DIV (cycle 5) → IDLE, out_valid 0, in_ready 0 while low.
  - A fresh window after release produces a correct result with no residue.

Source files
------------

// File: rtl/edge_avg_unit_pkg.sv
// edge_filt_pkg: shared widths, FSM states and the difference magnitude helper
package edge_filt_pkg;
  localparam int PIX_W = 8;
  localparam int DIFF_W = PIX_W + 1;
  localparam int SUM_W = 12;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;
  // 9'h100 maps to 256, which no 8-bit threshold can admit
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? -d : d;
  endfunction
endpackage

// File: rtl/edge_avg_unit_if.sv
// edge_avg_unit_if: neighbour-beat input stream and filtered-pixel output stream
interface edge_avg_unit_if #(parameter int PIX_W = 8);
  logic in_valid, in_ready, in_last;
  logic [PIX_W-1:0] in_center, in_thr, in_pix;
  logic [PIX_W:0] in_diff;
  logic out_valid, out_ready;
  logic [PIX_W-1:0] out_pix;
  logic [3:0] out_cnt;
  modport master(output in_valid, in_center, in_thr, in_pix, in_diff, in_last, out_ready,
                 input in_ready, out_valid, out_pix, out_cnt);
  modport slave(input in_valid, in_center, in_thr, in_pix, in_diff, in_last, out_ready,
                output in_ready, out_valid, out_pix, out_cnt);
endinterface

// File: rtl/edge_avg_unit_udiv_serial.sv
// udiv_serial: restoring unsigned divider, one quotient bit per cycle, MSB first
module udiv_serial #(parameter int DW = 12, parameter int VW = 4, parameter int QW = 8) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int IW = $clog2(DW);
  logic [DW-1:0] q;
  logic [VW-1:0] rem, dvs;
  logic [VW:0] trial;
  logic [IW-1:0] it;
  logic busy, ge;
  assign trial = {rem, q[DW-1]};
  assign ge = trial >= {1'b0, dvs};
  assign done = busy & (it == IW'(DW - 1));
  assign quotient = q[QW-1:0];
  // q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
      rem <= '0;
      dvs <= '0;
      it <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q <= dividend;
      rem <= '0;
      dvs <= divisor;
      it <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      q <= {q[DW-2:0], ge};
      rem <= ge ? VW'(trial - {1'b0, dvs}) : trial[VW-1:0];
      it <= it + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/edge_avg_unit.sv
// edge_avg_unit: averages the centre pixel with neighbours whose |diff| is within threshold
module edge_avg_unit #(parameter int PIX_W = 8, parameter int MAX_TAPS = 8) (
  input logic clk,
  input logic rst_n,
  edge_avg_unit_if.slave bus
);
  import edge_filt_pkg::*;
  state_t state, nxt;
  logic [PIX_W-1:0] thr, thr_sel, add;
  logic [SUM_W-1:0] sum, sum_n;
  logic [CNT_W-1:0] cnt, cnt_n, taps, taps_n;
  logic first, fire, acc, close, done;
  assign first = state == IDLE;
  assign bus.in_ready = rst_n & (state == IDLE | state == ACCUM);
  assign fire = bus.in_valid & bus.in_ready;
  assign thr_sel = first ? bus.in_thr : thr;
  assign acc = abs_diff(bus.in_diff) <= {1'b0, thr_sel};
  assign add = acc ? bus.in_pix : '0;
  assign sum_n = (first ? SUM_W'(bus.in_center) : sum) + SUM_W'(add);
  assign cnt_n = (first ? CNT_W'(1) : cnt) + CNT_W'(acc);
  assign taps_n = first ? CNT_W'(1) : taps + 1'b1;
  assign close = fire & (bus.in_last | taps_n == CNT_W'(MAX_TAPS));
  assign bus.out_valid = state == OUT;
  assign bus.out_cnt = cnt;
  always_comb begin
    nxt = close ? DIV : fire ? ACCUM : (state == DIV && done) ? OUT :
          (state == OUT && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
      taps <= '0;
      thr <= '0;
    end else if (fire) begin
      sum <= sum_n;
      cnt <= cnt_n;
      taps <= taps_n;
      if (first) thr <= bus.in_thr;
    end
  end
  // adding cnt/2 before the divide rounds half up
  udiv_serial #(.DW(SUM_W), .VW(CNT_W), .QW(PIX_W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(close),
    .dividend(sum_n + SUM_W'(cnt_n >> 1)),
    .divisor(cnt_n),
    .done(done),
    .quotient(bus.out_pix)
  );
endmodule
